// File: rtl/steer_en_pkg.sv
// Shared types and default limits for the rider-detect / steer-enable controller.
package steer_en_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETTLE   = 2'd1,
        STEER    = 2'd2,
        DISMOUNT = 2'd3
    } state_t;

    localparam int unsigned DEF_MIN_RIDER_WT    = 'h200;
    localparam int unsigned DEF_HYST            = 'h020;
    localparam int unsigned DEF_SETTLE_CYC      = 65_000_000;
    localparam int unsigned DEF_GRACE_CYC       = 12_500_000;
    localparam int unsigned DEF_FAST_SETTLE_CYC = 16;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/steer_tmr.sv
// Settle/grace timer: clears on clr, otherwise counts up and saturates at limit.
module steer_tmr
    import steer_en_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic             full
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clamp rather than hold, so a limit that shrinks mid-count still reaches full.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q < limit) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = limit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign full = (cnt_q == limit);

endmodule

// File: rtl/steer_en_ctrl.sv
// Rider-detect and steer-enable controller with settle timer.
// Define STEER_GRACE_EN to add the DISMOUNT grace state between STEER and IDLE.
module steer_en_ctrl
    import steer_en_pkg::*;
#(
    parameter int unsigned LOAD_W          = 12,
    parameter int unsigned MIN_RIDER_WT    = DEF_MIN_RIDER_WT,
    parameter int unsigned HYST            = DEF_HYST,
    parameter int unsigned SETTLE_CYC      = DEF_SETTLE_CYC,
    parameter int unsigned FAST_SETTLE_CYC = DEF_FAST_SETTLE_CYC,
    parameter int unsigned GRACE_CYC       = DEF_GRACE_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fast_sim,
    input  logic [LOAD_W-1:0] lft_load,
    input  logic [LOAD_W-1:0] rght_load,
    output logic              en_steer,
    output logic              rider_off,
    output logic              rider_on,
    output logic [1:0]        state_o
);

    localparam int unsigned SUM_W = LOAD_W + 1;
    localparam int unsigned CNT_W = $clog2(max_u(SETTLE_CYC, GRACE_CYC) + 1);
    localparam logic [SUM_W-1:0] THR_HI = SUM_W'(MIN_RIDER_WT + HYST);
    localparam logic [SUM_W-1:0] THR_LO = SUM_W'(MIN_RIDER_WT - HYST);

    state_t             state_q, state_d;
    logic               en_steer_q, rider_off_q, rider_on_q;
    logic               off_d, on_d, clr_tmr, tmr_full;
    logic [CNT_W-1:0]   limit;

    logic [SUM_W-1:0]        sum, sum_q4, thr15;
    logic signed [SUM_W-1:0] diff_s;
    logic [LOAD_W-1:0]       absdiff;
    logic                    sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16;

    assign sum     = {1'b0, lft_load} + {1'b0, rght_load};
    assign diff_s  = signed'({1'b0, lft_load}) - signed'({1'b0, rght_load});
    assign absdiff = diff_s[SUM_W-1] ? LOAD_W'(-diff_s) : LOAD_W'(diff_s);
    assign sum_q4  = sum >> 2;
    assign thr15   = (sum >> 4) * SUM_W'(15);

    assign sum_gt_min    = (sum > THR_HI);
    assign sum_lt_min    = (sum < THR_LO);
    assign diff_gt_1_4   = ({1'b0, absdiff} > sum_q4);
    assign diff_gt_15_16 = ({1'b0, absdiff} > thr15);

    always_comb begin
        limit = CNT_W'(SETTLE_CYC);
        if (fast_sim) begin
            limit = CNT_W'(FAST_SETTLE_CYC);
        end
`ifdef STEER_GRACE_EN
        else if (state_q == DISMOUNT) begin
            limit = CNT_W'(GRACE_CYC);
        end
`endif
    end

    steer_tmr #(.CNT_W(CNT_W)) u_tmr (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_tmr),
        .limit (limit),
        .full  (tmr_full)
    );

    always_comb begin
        state_d = state_q;
        clr_tmr = 1'b0;
        off_d   = 1'b0;
        on_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (sum_gt_min) begin
                    state_d = SETTLE;
                    clr_tmr = 1'b1;
                end
            end
            SETTLE: begin
                if (sum_lt_min) begin
                    state_d = IDLE;
                    off_d   = 1'b1;
                end else if (diff_gt_1_4) begin
                    clr_tmr = 1'b1;
                end else if (tmr_full) begin
                    state_d = STEER;
                    on_d    = 1'b1;
                end
            end
            STEER: begin
                if (sum_lt_min) begin
`ifdef STEER_GRACE_EN
                    state_d = DISMOUNT;
                    clr_tmr = 1'b1;
`else
                    state_d = IDLE;
                    off_d   = 1'b1;
`endif
                end else if (diff_gt_15_16) begin
                    state_d = SETTLE;
                    clr_tmr = 1'b1;
                end
            end
`ifdef STEER_GRACE_EN
            // The hysteresis band keeps counting here; only a clear re-mount cancels.
            DISMOUNT: begin
                if (sum_gt_min) begin
                    state_d = STEER;
                end else if (tmr_full) begin
                    state_d = IDLE;
                    off_d   = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            en_steer_q  <= 1'b0;
            rider_off_q <= 1'b0;
            rider_on_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            en_steer_q  <= (state_d == STEER) || (state_d == DISMOUNT);
            rider_off_q <= off_d;
            rider_on_q  <= on_d;
        end
    end

    assign en_steer  = en_steer_q;
    assign rider_off = rider_off_q;
    assign rider_on  = rider_on_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_steer_en_ctrl.sv
// Scoreboard bench for steer_en_ctrl: expected output-change events are queued with cycle stamps.
module tb_steer_en_ctrl;

    typedef struct {
        int unsigned cyc;
        logic [1:0]  st;
        logic        en_e;
        logic        on_e;
        logic        off_e;
    } evt_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        fast_sim;
    logic [11:0] lft_load;
    logic [11:0] rght_load;
    logic        en_steer;
    logic        rider_off;
    logic        rider_on;
    logic [1:0]  state_o;

    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    evt_t        sb[$];

    localparam logic [1:0] S_IDLE = 2'd0, S_SETTLE = 2'd1, S_STEER = 2'd2, S_DISM = 2'd3;

    steer_en_ctrl #(
        .LOAD_W          (12),
        .MIN_RIDER_WT    ('h200),
        .HYST            ('h020),
        .SETTLE_CYC      (65_000_000),
        .FAST_SETTLE_CYC (16),
        .GRACE_CYC       (12_500_000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fast_sim  (fast_sim),
        .lft_load  (lft_load),
        .rght_load (rght_load),
        .en_steer  (en_steer),
        .rider_off (rider_off),
        .rider_on  (rider_on),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every change of the output tuple is one observed event.
    logic [4:0] prev_obs;
    bit         first_smp = 1'b1;
    always @(negedge clk) begin
        logic [4:0] obs;
        evt_t       e;
        obs = {state_o, en_steer, rider_on, rider_off};
        if (first_smp || obs !== prev_obs) begin
            first_smp = 1'b0;
            prev_obs  = obs;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: cyc=%0d got st=%0d en=%b on=%b off=%b, required no change",
                         cyc, obs[4:3], obs[2], obs[1], obs[0]);
            end else begin
                e = sb.pop_front();
                if (e.cyc != cyc || obs !== {e.st, e.en_e, e.on_e, e.off_e}) begin
                    n_fail++;
                    $display("FAIL event@%0d: got cyc=%0d st=%0d en=%b on=%b off=%b, required cyc=%0d st=%0d en=%b on=%b off=%b",
                             e.cyc, cyc, obs[4:3], obs[2], obs[1], obs[0],
                             e.cyc, e.st, e.en_e, e.on_e, e.off_e);
                end
            end
        end
    end

    task automatic exp_evt(input int unsigned c, input logic [1:0] st,
                           input logic en_e, input logic on_e, input logic off_e);
        evt_t e;
        e.cyc = c; e.st = st; e.en_e = en_e; e.on_e = on_e; e.off_e = off_e;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic set_loads(input logic [11:0] l, input logic [11:0] r);
        lft_load  = l;
        rght_load = r;
    endtask

    initial begin
        rst = 1'b1;
        fast_sim = 1'b1;
        set_loads(12'h000, 12'h000);
        exp_evt(1, S_IDLE, 0, 0, 0);
        wait_cyc(2);
        rst = 1'b0;

        // Mount with balanced load: SETTLE next edge, STEER 17 cycles after first SETTLE cycle.
        wait_cyc(4);
        set_loads(12'h120, 12'h120);
        exp_evt(5, S_SETTLE, 0, 0, 0);
        exp_evt(22, S_STEER, 1, 1, 0);
        exp_evt(23, S_STEER, 1, 0, 0);

        // Sum 'h1E0 sits on the lower band edge: no change expected.
        wait_cyc(30);
        set_loads(12'h0F0, 12'h0F0);
        wait_cyc(35);
        set_loads(12'h0E0, 12'h0E0);
`ifdef STEER_GRACE_EN
        exp_evt(36, S_DISM, 1, 0, 0);
        exp_evt(53, S_IDLE, 0, 0, 1);
        exp_evt(54, S_IDLE, 0, 0, 0);
`else
        exp_evt(36, S_IDLE, 0, 0, 1);
        exp_evt(37, S_IDLE, 0, 0, 0);
`endif

        // Sum exactly 'h220 is not above threshold; 'h221 is.
        wait_cyc(60);
        set_loads(12'h110, 12'h110);
        wait_cyc(63);
        set_loads(12'h110, 12'h111);
        exp_evt(64, S_SETTLE, 0, 0, 0);
        wait_cyc(66);
        set_loads(12'h200, 12'h080);
        // Rebalance to absdiff == sum>>2 ('hC0), which must not count as imbalance.
        wait_cyc(76);
        set_loads(12'h1E0, 12'h120);
        exp_evt(93, S_STEER, 1, 1, 0);
        exp_evt(94, S_STEER, 1, 0, 0);

        // Brief dip then re-mount.
        wait_cyc(100);
        set_loads(12'h0E0, 12'h0E0);
`ifdef STEER_GRACE_EN
        exp_evt(101, S_DISM, 1, 0, 0);
        wait_cyc(105);
        set_loads(12'h120, 12'h120);
        exp_evt(106, S_STEER, 1, 0, 0);
`else
        exp_evt(101, S_IDLE, 0, 0, 1);
        exp_evt(102, S_IDLE, 0, 0, 0);
        wait_cyc(105);
        set_loads(12'h120, 12'h120);
        exp_evt(106, S_SETTLE, 0, 0, 0);
        exp_evt(123, S_STEER, 1, 1, 0);
        exp_evt(124, S_STEER, 1, 0, 0);
`endif

        // absdiff 'h3C0 equals 15*(sum>>4): stay; 'h3E0 exceeds it: back to SETTLE.
        wait_cyc(130);
        set_loads(12'h3E0, 12'h020);
        wait_cyc(133);
        set_loads(12'h3F0, 12'h010);
        exp_evt(134, S_SETTLE, 0, 0, 0);
        wait_cyc(138);
        set_loads(12'h120, 12'h120);
        exp_evt(155, S_STEER, 1, 1, 0);
        exp_evt(156, S_STEER, 1, 0, 0);

        // Full-scale loads must not wrap the sum.
        wait_cyc(160);
        set_loads(12'hFFF, 12'hFFF);

        // Reset mid-STEER: outputs clear with no rider_off; load still present on release.
        wait_cyc(165);
        rst = 1'b1;
        exp_evt(166, S_IDLE, 0, 0, 0);
        wait_cyc(167);
        rst = 1'b0;
        exp_evt(168, S_SETTLE, 0, 0, 0);

        wait_cyc(175);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL missing_events: got %0d events still pending, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
